// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/logic/compare operations plus a
// multi-cycle unsigned shift-and-add multiplier producing a double-width product.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } arith_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   result_nxt, result_hi_nxt;
    logic               c_nxt, z_nxt, n_nxt, v_nxt, done_nxt;
    arith_t             ar;
    logic [WIDTH:0]     psum;
    logic [2*WIDTH-1:0] prod;

    // Subtraction is add_op(x, ~y, 1), so carry-out is the no-borrow flag and
    // the overflow test sees the already-inverted B operand.
    function automatic arith_t add_op(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y,
                                      input logic             cin);
        arith_t         res;
        logic [WIDTH:0] s;
        s     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        res.r = s[WIDTH-1:0];
        res.c = s[WIDTH];
        res.v = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        return res;
    endfunction

    assign busy = (state == MUL);

    always_comb begin
        state_nxt     = state;
        mcand_nxt     = mcand;
        mplier_nxt    = mplier;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        result_nxt    = result;
        result_hi_nxt = result_hi;
        c_nxt         = flag_c;
        z_nxt         = flag_z;
        n_nxt         = flag_n;
        v_nxt         = flag_v;
        done_nxt      = 1'b0;
        ar            = '0;
        psum          = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        prod          = {psum, acc[WIDTH-1:1]};

        unique case (state)
            IDLE: begin
                if (start) begin
                    mcand_nxt  = a;
                    mplier_nxt = b;
                    if (op == OP_MUL) begin
                        state_nxt = MUL;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end else begin
                        done_nxt = 1'b1;
                        unique case (op)
                            OP_ADD:  ar = add_op(a, b, 1'b0);
                            OP_ADC:  ar = add_op(a, b, flag_c);
                            OP_SUB,
                            OP_CMP:  ar = add_op(a, ~b, 1'b1);
                            OP_AND:  ar.r = a & b;
                            OP_OR:   ar.r = a | b;
                            OP_XOR:  ar.r = a ^ b;
                            default: ar = '0;
                        endcase
                        c_nxt = ar.c;
                        v_nxt = ar.v;
                        z_nxt = (ar.r == '0);
                        n_nxt = ar.r[WIDTH-1];
                        // CMP only updates flags; the result registers keep their value.
                        if (op != OP_CMP) begin
                            result_nxt    = ar.r;
                            result_hi_nxt = '0;
                        end
                    end
                end
            end
            MUL: begin
                acc_nxt    = prod;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                    result_nxt    = prod[WIDTH-1:0];
                    result_hi_nxt = prod[2*WIDTH-1:WIDTH];
                    c_nxt         = (prod[2*WIDTH-1:WIDTH] != '0);
                    z_nxt         = (prod == '0);
                    n_nxt         = prod[2*WIDTH-1];
                    v_nxt         = 1'b0;
                    done_nxt      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            result_hi <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            result    <= result_nxt;
            result_hi <= result_hi_nxt;
            flag_c    <= c_nxt;
            flag_z    <= z_nxt;
            flag_n    <= n_nxt;
            flag_v    <= v_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=8): hand-computed vectors for every
// operation, MUL timing, start-while-busy, and reset during MUL.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk;
    logic         clr_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         flag_c, flag_z, flag_n, flag_v;
    logic         busy, done;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: result, result_hi, flags {c,z,n,v}, busy, done.
    task automatic chk_all(input string tag, input logic [7:0] r, input logic [7:0] rh,
                           input logic [3:0] czn_v, input logic bsy, input logic dn);
        chk({tag, ".result"}, 32'(result), 32'(r));
        chk({tag, ".result_hi"}, 32'(result_hi), 32'(rh));
        chk({tag, ".flags_cznv"}, 32'({flag_c, flag_z, flag_n, flag_v}), 32'(czn_v));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
    endtask

    initial begin
        clr_n = 1'b0;
        start = 1'b1;
        op    = 3'b000;
        a     = 8'h12;
        b     = 8'h34;
        tick();
        tick();
        chk_all("reset", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
        clr_n = 1'b1;
        start = 1'b0;
        tick();
        chk_all("idle_after_reset", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);

        issue(3'b000, 8'h7F, 8'h01);
        chk_all("add_7f_01", 8'h80, 8'h00, 4'b0011, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        chk_all("add_hold", 8'h80, 8'h00, 4'b0011, 1'b0, 1'b0);

        // Back-to-back single-cycle ops: done stays high on consecutive cycles.
        issue(3'b001, 8'h05, 8'h05);
        chk_all("sub_05_05", 8'h00, 8'h00, 4'b1100, 1'b0, 1'b1);
        issue(3'b001, 8'h03, 8'h05);
        chk_all("sub_03_05", 8'hFE, 8'h00, 4'b0010, 1'b0, 1'b1);
        issue(3'b111, 8'h03, 8'h05);
        chk_all("cmp_03_05", 8'hFE, 8'h00, 4'b0010, 1'b0, 1'b1);
        issue(3'b111, 8'h80, 8'h01);
        chk_all("cmp_80_01_ovf", 8'hFE, 8'h00, 4'b1001, 1'b0, 1'b1);

        issue(3'b000, 8'hFF, 8'h01);
        chk_all("add_ff_01", 8'h00, 8'h00, 4'b1100, 1'b0, 1'b1);
        issue(3'b101, 8'h00, 8'h00);
        chk_all("adc_carry_in", 8'h01, 8'h00, 4'b0000, 1'b0, 1'b1);
        issue(3'b101, 8'h10, 8'h20);
        chk_all("adc_no_carry", 8'h30, 8'h00, 4'b0000, 1'b0, 1'b1);
        issue(3'b000, 8'hFF, 8'h02);
        chk_all("add_ff_02", 8'h01, 8'h00, 4'b1000, 1'b0, 1'b1);
        issue(3'b010, 8'hF0, 8'h3C);
        chk_all("and", 8'h30, 8'h00, 4'b0000, 1'b0, 1'b1);
        issue(3'b011, 8'h0F, 8'h80);
        chk_all("or", 8'h8F, 8'h00, 4'b0010, 1'b0, 1'b1);
        issue(3'b100, 8'hAA, 8'hAA);
        chk_all("xor", 8'h00, 8'h00, 4'b0100, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        chk_all("idle_hold", 8'h00, 8'h00, 4'b0100, 1'b0, 1'b0);

        // MUL 0xFF*0xFF = 0xFE01, busy through k+7, done at k+8.
        issue(3'b110, 8'hFF, 8'hFF);
        start = 1'b0;
        chk_all("mul_ff_k", 8'h00, 8'h00, 4'b0100, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_all("mul_ff_iter", 8'h00, 8'h00, 4'b0100, 1'b1, 1'b0);
        end
        tick();
        chk_all("mul_ff_done", 8'h01, 8'hFE, 4'b1010, 1'b0, 1'b1);
        tick();
        chk_all("mul_ff_after", 8'h01, 8'hFE, 4'b1010, 1'b0, 1'b0);

        issue(3'b000, 8'h01, 8'h01);
        chk_all("add_clears_hi", 8'h02, 8'h00, 4'b0000, 1'b0, 1'b1);

        issue(3'b110, 8'h0F, 8'h11);
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        chk_all("mul_0f_pre", 8'h02, 8'h00, 4'b0000, 1'b1, 1'b0);
        tick();
        chk_all("mul_0f_11", 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b1);

        // Start pulsed mid-MUL is ignored without queuing.
        issue(3'b110, 8'h03, 8'h05);
        start = 1'b0;
        tick();
        tick();
        tick();
        start = 1'b1;
        op    = 3'b000;
        a     = 8'h01;
        b     = 8'h01;
        tick();
        start = 1'b0;
        chk_all("mul_ign_k4", 8'hFF, 8'h00, 4'b0000, 1'b1, 1'b0);
        for (int i = 5; i < 8; i++) tick();
        chk_all("mul_ign_k7", 8'hFF, 8'h00, 4'b0000, 1'b1, 1'b0);
        tick();
        chk_all("mul_ign_done", 8'h0F, 8'h00, 4'b0000, 1'b0, 1'b1);
        tick();
        chk_all("mul_ign_noqueue", 8'h0F, 8'h00, 4'b0000, 1'b0, 1'b0);

        // Reset at k+4 aborts the MUL with no done pulse.
        issue(3'b110, 8'hFF, 8'hFF);
        start = 1'b0;
        tick();
        tick();
        tick();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        chk_all("mul_reset", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all("mul_reset_nodone", 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0);
        end
        issue(3'b000, 8'h02, 8'h03);
        start = 1'b0;
        chk_all("add_after_reset", 8'h05, 8'h00, 4'b0000, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clr_n  input  1  reset; synchronous, active-low; sampled on rising clk.
REQ-004 start  input  1  request strobe; sampled only while busy=0.
REQ-005 op  input  3  operation select: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 ADC, 110 MUL, 111 CMP.
REQ-006 a  input  WIDTH  operand A, unsigned / two's complement.
REQ-007 b  input  WIDTH  operand B, unsigned / two's complement.
REQ-008 result  output  WIDTH  registered result; MUL low half.
REQ-009 result_hi  output  WIDTH  registered MUL high half; 0 for all other ops.
REQ-010 flag_c, flag_z, flag_n, flag_v  output  1 each  registered carry, zero, negative, overflow.
REQ-011 busy  output  1  high while a MUL is iterating.
REQ-012 done  output  1  one-cycle pulse when result/flags are updated.

Function
REQ-013 The block SHALL have states IDLE and MUL; reset enters IDLE.
REQ-014 In IDLE, start=1 at edge k SHALL latch a, b, op; for ops other than MUL, result and flags SHALL update at edge k, done=1 for the following cycle only, and the state SHALL stay IDLE.
REQ-015 Back-to-back single-cycle ops SHALL be accepted every cycle (done high on consecutive cycles).
REQ-016 ADD: {c,result}=a+b; SUB: a+~b+1 with flag_c = no-borrow (1 when a>=b unsigned); ADC: a+b+flag_c (flag_c as held before edge k).
REQ-017 flag_v SHALL be the signed overflow of ADD/SUB/ADC/CMP: operand MSBs equal (after B inversion for SUB/CMP) and result MSB different.
REQ-018 AND/OR/XOR SHALL set flag_c=0 and flag_v=0.
REQ-019 CMP SHALL compute flags exactly as SUB but leave result and result_hi unchanged.
REQ-020 flag_z SHALL be 1 when the WIDTH-bit result is 0 (2*WIDTH product for MUL); flag_n SHALL equal result MSB (result_hi MSB for MUL).
REQ-021 MUL: start at edge k SHALL enter MUL with busy=1 from edge k; unsigned shift-and-add, one multiplier bit per cycle, WIDTH iterations.
REQ-022 At edge k+WIDTH the block SHALL write the 2*WIDTH product to {result_hi,result}, set done=1 for one cycle, busy=0, and return to IDLE.
REQ-023 MUL flags: flag_c=1 iff result_hi!=0; flag_v=0.
REQ-024 result, result_hi and flags SHALL hold their values during MUL iteration and while idle without start.
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 A new start may be accepted at the same edge where done is asserted for a prior MUL completion; it SHALL then be treated as issued in IDLE on the next edge (busy=0 cycle).
REQ-027 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-028 clr_n=0 at a rising edge SHALL force state IDLE, result=0, result_hi=0, all flags=0, busy=0, done=0, internal operands/counter=0.
REQ-029 Reset during MUL SHALL abort the operation with no done pulse; start coincident with clr_n=0 SHALL be ignored.

Verification (WIDTH=8)
REQ-030 ADD a=0x7F b=0x01 -> result 0x80, c0 z0 n1 v1, done one cycle after start edge.
REQ-031 SUB 0x05-0x05 -> 0x00, c1 z1 n0 v0; SUB 0x03-0x05 -> 0xFE, c0 n1 v0; CMP 0x03,0x05 -> same flags, result holds 0xFE.
REQ-032 ADD 0xFF+0x01 -> 0x00 c1 z1; then ADC 0x00+0x00 -> 0x01 c0 z0.
REQ-033 MUL 0xFF*0xFF -> result 0x01, result_hi 0xFE, c1, busy for 8 cycles, done at edge k+8; MUL 0x0F*0x11 -> 0xFF/0x00, c0.
REQ-034 MUL started, start+ADD pulsed at cycle k+3 -> ignored; result matches MUL only.
REQ-035 clr_n=0 at cycle k+4 of a MUL -> all outputs 0, busy 0, no done; next ADD 0x02+0x03 -> 0x05.
